// File: rtl/fir_channel_scheduler_pkg.sv
// fir_sched_pkg: shared types and helpers for the FIR channel scheduler.
// Provides the FSM state enum, the channel-ID width and the channel-ID type.
package fir_sched_pkg;

    localparam int NUM_CH_DEFAULT = 3;

    // A single channel still needs a 1-bit ID so the tag FIFO has a width.
    function automatic int ch_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_ID_W = ch_id_width(NUM_CH_DEFAULT);

    typedef enum logic {IDLE, SEND} sched_state_t;

    typedef logic [CH_ID_W-1:0] ch_id_t;

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// fir_channel_scheduler_if: bus bundle between the I2S receivers, the shared FIR and the scheduler.
// Signals: ch_valid_in/ch_data_in (capture), fir_tvalid_out/fir_tready_in/fir_tdata_out (FIR slave),
// fir_m_tvalid_in/fir_m_tdata_in (FIR master), filt_valid_out/filt_data_out (results),
// overrun_out/tag_err_out/overrun_cnt_out (status).
// Modports: master = scheduler side, slave = environment side.
interface fir_channel_scheduler_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 16
);

    logic [NUM_CH-1:0]        ch_valid_in;
    logic [NUM_CH*DATA_W-1:0] ch_data_in;
    logic                     fir_tvalid_out;
    logic                     fir_tready_in;
    logic [DATA_W-1:0]        fir_tdata_out;
    logic                     fir_m_tvalid_in;
    logic [DATA_W-1:0]        fir_m_tdata_in;
    logic [NUM_CH-1:0]        filt_valid_out;
    logic [NUM_CH*DATA_W-1:0] filt_data_out;
    logic [NUM_CH-1:0]        overrun_out;
    logic                     tag_err_out;
    logic [NUM_CH*8-1:0]      overrun_cnt_out;

    modport master (
        input  ch_valid_in, ch_data_in, fir_tready_in, fir_m_tvalid_in, fir_m_tdata_in,
        output fir_tvalid_out, fir_tdata_out, filt_valid_out, filt_data_out,
               overrun_out, tag_err_out, overrun_cnt_out
    );

    modport slave (
        output ch_valid_in, ch_data_in, fir_tready_in, fir_m_tvalid_in, fir_m_tdata_in,
        input  fir_tvalid_out, fir_tdata_out, filt_valid_out, filt_data_out,
               overrun_out, tag_err_out, overrun_cnt_out
    );

endinterface

// File: rtl/fir_channel_scheduler_tag_fifo.sv
// sched_tag_fifo: synchronous FIFO holding the channel IDs of samples in flight through the FIR.
// Ports: clk_in, rst_in (sync, active-low), push/din, pop/dout (show-ahead), full, empty.
module sched_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: round-robin sharing of one FIR across mic channels, with result steering by tag.
// Ports: clk_in (audio clock), rst_in (sync, active-low), bus (fir_channel_scheduler_if.master):
// per-channel capture strobes/data in, FIR slave handshake out, FIR master results in,
// per-channel filtered outputs with valid pulses, sticky overrun/tag-error flags, overrun counters.
// Optional feature: define FIR_SCHED_OVERRUN_CNT_EN to build saturating 8-bit per-channel overrun
// counters; otherwise overrun_cnt_out is tied to zero.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 16,
    parameter int TAG_DEPTH = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    fir_channel_scheduler_if.master bus
);

    localparam int IDW = ch_id_width(NUM_CH);

    sched_state_t      state, state_nx;
    logic [NUM_CH-1:0] pending;
    logic [DATA_W-1:0] hold [NUM_CH];
    logic [IDW-1:0]    rr_ptr, sel, pick, tag_dout;
    logic [IDW:0]      cand;
    logic [NUM_CH-1:0] ovr_ev;
    logic              found, launch, xfer, tag_full, tag_empty, tag_pop;

    // Scan channels starting at rr_ptr; the wrap is a subtract so no divider is built.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NUM_CH)) cand = cand - (IDW+1)'(NUM_CH);
            if (!found && pending[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    assign launch  = (state == IDLE) && found && !tag_full;
    assign xfer    = (state == SEND) && bus.fir_tready_in;
    assign tag_pop = bus.fir_m_tvalid_in && !tag_empty;

    always_ff @(posedge clk_in) begin
        state <= !rst_in ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = launch ? SEND : xfer ? IDLE : state;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus.fir_tvalid_out <= 1'b0;
            bus.fir_tdata_out  <= '0;
            rr_ptr             <= '0;
            sel                <= '0;
        end else if (launch) begin
            bus.fir_tvalid_out <= 1'b1;
            bus.fir_tdata_out  <= hold[pick];
            sel                <= pick;
        end else if (xfer) begin
            bus.fir_tvalid_out <= 1'b0;
            rr_ptr             <= (sel == IDW'(NUM_CH-1)) ? '0 : sel + 1'b1;
        end
    end

    // A strobe on the channel being launched refills the slot rather than overwriting it.
    always_comb begin
        ovr_ev = '0;
        for (int k = 0; k < NUM_CH; k++)
            ovr_ev[k] = bus.ch_valid_in[k] && pending[k] && !(launch && pick == IDW'(k));
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pending         <= '0;
            bus.overrun_out <= '0;
            for (int k = 0; k < NUM_CH; k++) hold[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (bus.ch_valid_in[k]) hold[k] <= bus.ch_data_in[k*DATA_W +: DATA_W];
                pending[k] <= bus.ch_valid_in[k] || (pending[k] && !(launch && pick == IDW'(k)));
                if (ovr_ev[k]) bus.overrun_out[k] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus.filt_valid_out <= '0;
            bus.filt_data_out  <= '0;
            bus.tag_err_out    <= 1'b0;
        end else begin
            bus.filt_valid_out <= '0;
            if (tag_pop) begin
                bus.filt_valid_out[tag_dout]                 <= 1'b1;
                bus.filt_data_out[tag_dout*DATA_W +: DATA_W] <= bus.fir_m_tdata_in;
            end
            if (bus.fir_m_tvalid_in && tag_empty) bus.tag_err_out <= 1'b1;
        end
    end

`ifdef FIR_SCHED_OVERRUN_CNT_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            bus.overrun_cnt_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++)
                if (ovr_ev[k] && bus.overrun_cnt_out[k*8 +: 8] != 8'hFF)
                    bus.overrun_cnt_out[k*8 +: 8] <= bus.overrun_cnt_out[k*8 +: 8] + 8'd1;
        end
    end
`else
    assign bus.overrun_cnt_out = '0;
`endif

    sched_tag_fifo #(
        .WIDTH(IDW),
        .DEPTH(TAG_DEPTH)
    ) u_tags (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .push  (launch),
        .din   (pick),
        .pop   (tag_pop),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule
